// File: rtl/upsamp_sched_if.sv
// Mapper-side symbol stream and register bus of the upsampler symbol scheduler.
interface upsamp_sched_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] sym_in;
    logic              sym_valid;
    logic              sym_ready;
    logic              cfg_wr;
    logic              cfg_rd;
    logic [7:0]        cfg_addr;
    logic [11:0]       cfg_wdata;
    logic [11:0]       cfg_rdata;

    modport master (
        output sym_in, sym_valid, cfg_wr, cfg_rd, cfg_addr, cfg_wdata,
        input  sym_ready, cfg_rdata
    );

    modport slave (
        input  sym_in, sym_valid, cfg_wr, cfg_rd, cfg_addr, cfg_wdata,
        output sym_ready, cfg_rdata
    );
endinterface

// File: rtl/upsamp_sched.sv
// Symbol scheduler: buffers mapper symbols, issues one per upsampling period, owns the rate register.
// Optional feature: define UPSAMP_UNDERRUN_CNT_EN for the saturating underrun counter at 0x03.
module upsamp_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int RATE_W     = 9,
    parameter int DATA_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    upsamp_sched_if.slave     bus,
    output logic [DATA_W-1:0] data_in,
    output logic              valid_data,
    output logic [RATE_W-1:0] upsampling_rate,
    output logic              busy,
    output logic              underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]     level, lvl_next;
    logic              full, empty, empty_next;
    logic              push, pop;
    logic              ctrl_en, flush_q;
    logic [RATE_W-1:0] rate_shadow, r_eff, cnt;
    logic              wr_ctrl, wr_rate, wr_ucnt;
    logic [11:0]       status, rd_mux, ucnt_rd;
    state_t            end_state;
    logic              end_und;
    logic              unused_wdata;

    assign unused_wdata = ^bus.cfg_wdata;

    assign level         = wr_ptr - rd_ptr;
    assign full          = (level == LW'(FIFO_DEPTH));
    assign empty         = (level == '0);
    assign bus.sym_ready = !full;
    // A push landing in the flush cycle is discarded along with the buffer contents.
    assign push          = bus.sym_valid && !full && !flush_q;
    assign pop           = (state == S_ISSUE);
    assign lvl_next      = level + LW'(push) - LW'(pop);
    assign empty_next    = flush_q || (lvl_next == '0);

    assign r_eff     = (rate_shadow == '0) ? RATE_W'(1) : rate_shadow;
    assign end_state = (ctrl_en && !empty_next) ? S_ISSUE : S_IDLE;
    assign end_und   = ctrl_en && empty_next;

    assign wr_ctrl = bus.cfg_wr && (bus.cfg_addr == 8'h00);
    assign wr_rate = bus.cfg_wr && (bus.cfg_addr == 8'h01);
    assign wr_ucnt = bus.cfg_wr && (bus.cfg_addr == 8'h03);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.sym_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_q) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_en     <= 1'b0;
            flush_q     <= 1'b0;
            rate_shadow <= '0;
        end else begin
            flush_q <= wr_ctrl && bus.cfg_wdata[1];
            if (wr_ctrl) ctrl_en     <= bus.cfg_wdata[0];
            if (wr_rate) rate_shadow <= bus.cfg_wdata[RATE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            data_in         <= '0;
            valid_data      <= 1'b0;
            upsampling_rate <= '0;
            cnt             <= '0;
            busy            <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            valid_data <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ctrl_en && !empty && !flush_q) begin
                        state <= S_ISSUE;
                        busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    data_in         <= mem[rd_ptr[AW-1:0]];
                    valid_data      <= 1'b1;
                    upsampling_rate <= rate_shadow;
                    cnt             <= r_eff - RATE_W'(1);
                    if (r_eff == RATE_W'(1)) begin
                        state    <= end_state;
                        busy     <= (end_state != S_IDLE);
                        underrun <= end_und;
                    end else begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // cnt==1 marks the final cycle of the symbol period.
                    if (cnt == RATE_W'(1)) begin
                        state    <= end_state;
                        busy     <= (end_state != S_IDLE);
                        underrun <= end_und;
                    end else begin
                        cnt <= cnt - RATE_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UPSAMP_UNDERRUN_CNT_EN
    logic [7:0] ucnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ucnt <= '0;
        end else if (wr_ucnt) begin
            ucnt <= '0;
        end else if (underrun && (ucnt != 8'hFF)) begin
            ucnt <= ucnt + 8'd1;
        end
    end

    assign ucnt_rd = {4'b0000, ucnt};
`else
    logic unused_ucnt;
    assign unused_ucnt = wr_ucnt;
    assign ucnt_rd     = '0;
`endif

    always_comb begin
        status      = '0;
        status[9:8] = state;
        status[2:0] = 3'(level);
    end

    always_comb begin
        rd_mux = '0;
        case (bus.cfg_addr)
            8'h00:   rd_mux = {11'd0, ctrl_en};
            8'h01:   rd_mux = 12'(rate_shadow);
            8'h02:   rd_mux = status;
            8'h03:   rd_mux = ucnt_rd;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.cfg_rdata <= '0;
        end else if (bus.cfg_rd) begin
            bus.cfg_rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_upsamp_sched.sv
// Directed bench for upsamp_sched: cycle vector table plus hand-written multi-cycle sequences.
module tb_upsamp_sched;
    logic       clk;
    logic       rst;
    logic [3:0] data_in;
    logic       valid_data;
    logic [8:0] upsampling_rate;
    logic       busy;
    logic       underrun;
    int         checks;
    int         errors;

    upsamp_sched_if #(.DATA_W(4)) bus ();

    upsamp_sched #(.FIFO_DEPTH(4), .RATE_W(9), .DATA_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .data_in         (data_in),
        .valid_data      (valid_data),
        .upsampling_rate (upsampling_rate),
        .busy            (busy),
        .underrun        (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [11:0] wd;
        logic        sv;
        logic [3:0]  sym;
        logic        vd;
        logic [3:0]  d;
        logic [8:0]  rt;
        logic        rdy;
        logic        bsy;
        logic        und;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic wr, input logic [7:0] addr, input logic [11:0] wd,
                                input logic sv, input logic [3:0] sym, input logic vd,
                                input logic [3:0] d, input logic [8:0] rt, input logic rdy,
                                input logic bsy, input logic und);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wd = wd; v.sv = sv; v.sym = sym;
        v.vd = vd; v.d = d; v.rt = rt; v.rdy = rdy; v.bsy = bsy; v.und = und;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [11:0] wd);
        bus.cfg_wr    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wd;
        @(negedge clk);
        bus.cfg_wr = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] addr, output logic [11:0] rd);
        bus.cfg_rd   = 1'b1;
        bus.cfg_addr = addr;
        @(negedge clk);
        bus.cfg_rd = 1'b0;
        rd = bus.cfg_rdata;
    endtask

    task automatic push(input logic [3:0] sym);
        bus.sym_valid = 1'b1;
        bus.sym_in    = sym;
        @(negedge clk);
        bus.sym_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] rd;
        logic [31:0] act, exp;
        int          n, ut;
        int          t [3];
        logic [3:0]  dd [3];
        logic [8:0]  rr [3];
        bit          wrote;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.sym_in = '0; bus.sym_valid = 1'b0;
        bus.cfg_wr = 1'b0; bus.cfg_rd = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;

        // wr addr wd | sv sym | vd d rate rdy busy und
        tbl[0]  = mk(1, 8'h01, 12'd4, 0, 4'h0, 0, 4'h0, 9'd0, 1, 0, 0);
        tbl[1]  = mk(1, 8'h00, 12'd1, 0, 4'h0, 0, 4'h0, 9'd0, 1, 0, 0);
        tbl[2]  = mk(0, 8'h00, 12'd0, 1, 4'hA, 0, 4'h0, 9'd0, 1, 0, 0);
        tbl[3]  = mk(0, 8'h00, 12'd0, 1, 4'h5, 0, 4'h0, 9'd0, 1, 1, 0);
        tbl[4]  = mk(0, 8'h00, 12'd0, 0, 4'h0, 1, 4'hA, 9'd4, 1, 1, 0);
        tbl[5]  = mk(0, 8'h00, 12'd0, 0, 4'h0, 0, 4'hA, 9'd4, 1, 1, 0);
        tbl[6]  = mk(0, 8'h00, 12'd0, 0, 4'h0, 0, 4'hA, 9'd4, 1, 1, 0);
        tbl[7]  = mk(0, 8'h00, 12'd0, 0, 4'h0, 0, 4'hA, 9'd4, 1, 1, 0);
        tbl[8]  = mk(0, 8'h00, 12'd0, 0, 4'h0, 1, 4'h5, 9'd4, 1, 1, 0);
        tbl[9]  = mk(0, 8'h00, 12'd0, 0, 4'h0, 0, 4'h5, 9'd4, 1, 1, 0);
        tbl[10] = mk(0, 8'h00, 12'd0, 0, 4'h0, 0, 4'h5, 9'd4, 1, 1, 0);
        tbl[11] = mk(0, 8'h00, 12'd0, 0, 4'h0, 0, 4'h5, 9'd4, 1, 0, 1);
        tbl[12] = mk(1, 8'h01, 12'd0, 0, 4'h0, 0, 4'h5, 9'd4, 1, 0, 0);
        tbl[13] = mk(0, 8'h00, 12'd0, 1, 4'h1, 0, 4'h5, 9'd4, 1, 0, 0);
        tbl[14] = mk(0, 8'h00, 12'd0, 1, 4'h2, 0, 4'h5, 9'd4, 1, 1, 0);
        tbl[15] = mk(0, 8'h00, 12'd0, 1, 4'h3, 1, 4'h1, 9'd0, 1, 1, 0);
        tbl[16] = mk(0, 8'h00, 12'd0, 1, 4'hC, 1, 4'h2, 9'd0, 1, 1, 0);
        tbl[17] = mk(0, 8'h00, 12'd0, 0, 4'h0, 1, 4'h3, 9'd0, 1, 1, 0);
        tbl[18] = mk(0, 8'h00, 12'd0, 0, 4'h0, 1, 4'hC, 9'd0, 1, 0, 1);
        tbl[19] = mk(0, 8'h00, 12'd0, 0, 4'h0, 0, 4'hC, 9'd0, 1, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_valid_data", 32'(valid_data), 0);
        check("rst_data_in", 32'(data_in), 0);
        check("rst_rate", 32'(upsampling_rate), 0);
        check("rst_cfg_rdata", 32'(bus.cfg_rdata), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sym_ready", 32'(bus.sym_ready), 1);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            bus.cfg_wr    = tbl[i].wr;
            bus.cfg_addr  = tbl[i].addr;
            bus.cfg_wdata = tbl[i].wd;
            bus.sym_valid = tbl[i].sv;
            bus.sym_in    = tbl[i].sym;
            @(negedge clk);
            act = {15'd0, valid_data, data_in, upsampling_rate, bus.sym_ready, busy, underrun};
            exp = {15'd0, tbl[i].vd, tbl[i].d, tbl[i].rt, tbl[i].rdy, tbl[i].bsy, tbl[i].und};
            check($sformatf("vec%0d {vd,d,rate,rdy,busy,und}", i), act, exp);
        end
        bus.cfg_wr = 1'b0;
        bus.sym_valid = 1'b0;

        // Disabled: fill the buffer and try one more.
        cfg_write(8'h00, 12'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill_ready%0d", i), 32'(bus.sym_ready), (i < 4) ? 1 : 0);
            push(4'(i + 4));
        end
        check("fill_busy", 32'(busy), 0);
        cfg_read(8'h02, rd);
        check("fill_status", 32'(rd), 32'h004);

        cfg_write(8'h00, 12'h002);
        @(negedge clk);
        cfg_read(8'h02, rd);
        check("flush_status", 32'(rd), 32'h000);
        cfg_read(8'h00, rd);
        check("ctrl_after_flush", 32'(rd), 32'h000);

        push(4'h7);
        cfg_write(8'h00, 12'h002);
        push(4'h8);
        cfg_read(8'h02, rd);
        check("flush_drop_push", 32'(rd), 32'h000);

        // Rate change mid-HOLD takes effect at the next issue.
        push(4'h9);
        push(4'h6);
        push(4'h3);
        cfg_write(8'h01, 12'd8);
        cfg_write(8'h00, 12'd1);
        n = 0; ut = -1; wrote = 1'b0;
        t[0] = 0; t[1] = 0; t[2] = 0;
        dd[0] = 0; dd[1] = 0; dd[2] = 0; rr[0] = 0; rr[1] = 0; rr[2] = 0;
        for (int c = 0; c < 40; c++) begin
            bus.cfg_wr = 1'b0;
            if (n == 1 && !wrote) begin
                bus.cfg_wr = 1'b1; bus.cfg_addr = 8'h01; bus.cfg_wdata = 12'd3;
                wrote = 1'b1;
            end
            @(negedge clk);
            if (valid_data && n < 3) begin
                t[n] = c; dd[n] = data_in; rr[n] = upsampling_rate;
                n++;
            end
            if (underrun && ut < 0) ut = c;
        end
        bus.cfg_wr = 1'b0;
        check("rate_strobe_count", 32'(n), 3);
        check("rate_period1", 32'(t[1] - t[0]), 8);
        check("rate_period2", 32'(t[2] - t[1]), 3);
        check("rate_at_strobe1", 32'(rr[0]), 8);
        check("rate_at_strobe2", 32'(rr[1]), 3);
        check("rate_at_strobe3", 32'(rr[2]), 3);
        check("data_strobe1", 32'(dd[0]), 4'h9);
        check("data_strobe2", 32'(dd[1]), 4'h6);
        check("data_strobe3", 32'(dd[2]), 4'h3);
        check("underrun_after_last", 32'(ut - t[2]), 2);

        cfg_read(8'h01, rd);
        check("rate_readback", 32'(rd), 3);
        cfg_read(8'h07, rd);
        check("unmapped_read", 32'(rd), 0);
        cfg_read(8'h03, rd);
`ifdef UPSAMP_UNDERRUN_CNT_EN
        check("ucnt_three", 32'(rd), 3);
`else
        check("ucnt_absent", 32'(rd), 0);
`endif
        cfg_write(8'h03, 12'd0);
        cfg_read(8'h03, rd);
        check("ucnt_cleared", 32'(rd), 0);

        // Asynchronous reset in the middle of a long period.
        cfg_write(8'h01, 12'd8);
        push(4'hE);
        repeat (4) @(negedge clk);
        check("hold_busy", 32'(busy), 1);
        check("hold_data", 32'(data_in), 4'hE);
        check("hold_rate", 32'(upsampling_rate), 8);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_data_in", 32'(data_in), 0);
        check("arst_rate", 32'(upsampling_rate), 0);
        check("arst_valid_data", 32'(valid_data), 0);
        check("arst_sym_ready", 32'(bus.sym_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        cfg_read(8'h02, rd);
        check("arst_status", 32'(rd), 0);
        cfg_read(8'h01, rd);
        check("arst_rate_shadow", 32'(rd), 0);
        cfg_read(8'h00, rd);
        check("arst_ctrl", 32'(rd), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
